// File: rtl/pc_flag_unit.sv
// PC, N/Z/V flag register, halt FSM and retired-instruction counter behind the decoder.
// Applies decoder outputs on each retiring edge; stalls and HALT freeze all state.
module pc_flag_unit #(
    parameter int                    PC_WIDTH  = 16,
    parameter logic [PC_WIDTH-1:0]   RESET_PC  = '0,
    parameter int                    CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 stall,
    input  logic                 pc_write,
    input  logic                 branch,
    input  logic                 br_reg,
    input  logic [8:0]           imm9,
    input  logic [PC_WIDTH-1:0]  rs_data,
    input  logic                 set_n,
    input  logic                 set_z,
    input  logic                 set_v,
    input  logic [PC_WIDTH-1:0]  alu_result,
    input  logic                 alu_ovfl,
    output logic [PC_WIDTH-1:0]  pc,
    output logic [PC_WIDTH-1:0]  pc_plus2,
    output logic                 flag_n,
    output logic                 flag_z,
    output logic                 flag_v,
    output logic                 halted,
    output logic [CNT_WIDTH-1:0] retired_cnt
);

    typedef enum logic {RUN, HALT} state_t;

    typedef struct packed {
        logic n;
        logic z;
        logic v;
    } flags_t;

    state_t              state_q, state_d;
    flags_t              flags_q, flags_d;
    logic [PC_WIDTH-1:0] pc_q, pc_d;
    logic [PC_WIDTH-1:0] imm_ext, br_off;
    logic                retire;
    logic                cnt_sat;

    assign retire   = (state_q == RUN) && !stall;
    assign pc_plus2 = pc_q + PC_WIDTH'(2);
    assign imm_ext  = {{(PC_WIDTH-9){imm9[8]}}, imm9};
    assign br_off   = imm_ext << 1;
    assign cnt_sat  = &retired_cnt;

    // Next-state: nothing moves unless the instruction actually retires.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        flags_d = flags_q;
        if (retire) begin
            if (!pc_write) begin
                state_d = HALT;
            end else begin
                // br_reg outranks branch if the decoder ever raises both.
                if (br_reg)
                    pc_d = rs_data;
                else if (branch)
                    pc_d = pc_plus2 + br_off;
                else
                    pc_d = pc_plus2;
                if (set_n) flags_d.n = alu_result[PC_WIDTH-1];
                if (set_z) flags_d.z = (alu_result == '0);
                if (set_v) flags_d.v = alu_ovfl;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= RUN;
            pc_q        <= RESET_PC;
            flags_q     <= '0;
            halted      <= 1'b0;
            retired_cnt <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            flags_q <= flags_d;
            halted  <= (state_d == HALT);
            if (retire && !cnt_sat)
                retired_cnt <= retired_cnt + CNT_WIDTH'(1);
        end
    end

    assign pc     = pc_q;
    assign flag_n = flags_q.n;
    assign flag_z = flags_q.z;
    assign flag_v = flags_q.v;

endmodule

// File: tb/tb_pc_flag_unit.sv
// Directed-vector bench for pc_flag_unit; small CNT_WIDTH so counter saturation is reachable.
module tb_pc_flag_unit;
    localparam int PW = 16;
    localparam int CW = 5;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          stall, pc_write, branch, br_reg;
    logic [8:0]    imm9;
    logic [PW-1:0] rs_data, alu_result;
    logic          set_n, set_z, set_v, alu_ovfl;
    logic [PW-1:0] pc, pc_plus2;
    logic          flag_n, flag_z, flag_v, halted;
    logic [CW-1:0] retired_cnt;

    int checks = 0;
    int errors = 0;

    pc_flag_unit #(.PC_WIDTH(PW), .RESET_PC(16'h0000), .CNT_WIDTH(CW)) dut (
        .clk(clk), .rst_n(rst_n), .stall(stall), .pc_write(pc_write),
        .branch(branch), .br_reg(br_reg), .imm9(imm9), .rs_data(rs_data),
        .set_n(set_n), .set_z(set_z), .set_v(set_v),
        .alu_result(alu_result), .alu_ovfl(alu_ovfl),
        .pc(pc), .pc_plus2(pc_plus2),
        .flag_n(flag_n), .flag_z(flag_z), .flag_v(flag_v),
        .halted(halted), .retired_cnt(retired_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        stall = 0; pc_write = 1; branch = 0; br_reg = 0; imm9 = '0; rs_data = '0;
        set_n = 0; set_z = 0; set_v = 0; alu_result = '0; alu_ovfl = 0;
    endtask

    initial begin
        idle_inputs();
        rst_n = 0;
        #13;
        chk("rst_pc", pc, 0);
        chk("rst_halted", halted, 0);
        chk("rst_cnt", retired_cnt, 0);
        chk("rst_flags", {flag_n, flag_z, flag_v}, 0);
        @(negedge clk);
        rst_n = 1;
        #1;

        // sequential retires
        step(); chk("seq_pc1", pc, 16'h0002);
        step(); chk("seq_pc2", pc, 16'h0004);
        step(); chk("seq_pc3", pc, 16'h0006);
        chk("seq_cnt", retired_cnt, 3);
        chk("seq_flags", {flag_n, flag_z, flag_v}, 0);

        // PC-relative branches
        br_reg = 1; rs_data = 16'h0010; step(); br_reg = 0;
        chk("br_load", pc, 16'h0010);
        branch = 1; imm9 = 9'h1FE; step();
        chk("b_neg", pc, 16'h000E);
        branch = 0; br_reg = 1; rs_data = 16'h0010; step(); br_reg = 0;
        branch = 1; imm9 = 9'h0FF; step(); branch = 0;
        chk("b_pos", pc, 16'h0210);
        chk("b_cnt", retired_cnt, 7);

        // br_reg beats branch; wraparound
        branch = 1; br_reg = 1; imm9 = 9'h004; rs_data = 16'h1234; step();
        chk("prio_pc", pc, 16'h1234);
        chk("plus2", pc_plus2, 16'h1236);
        branch = 0; rs_data = 16'hFFFE; step(); br_reg = 0;
        chk("plus2_wrap", pc_plus2, 16'h0000);
        step();
        chk("pc_wrap", pc, 16'h0000);

        // flags
        set_n = 1; set_z = 1; alu_result = 16'h8000; alu_ovfl = 1;
        chk("flag_pre", flag_n, 0);
        step();
        chk("flags_a", {flag_n, flag_z, flag_v}, 3'b100);
        set_n = 0; alu_result = 16'h0000; step();
        chk("flags_b", {flag_n, flag_z, flag_v}, 3'b110);
        set_z = 0; set_v = 1; alu_ovfl = 1; step(); set_v = 0;
        chk("flags_c", {flag_n, flag_z, flag_v}, 3'b111);
        chk("flags_pc", pc, 16'h0006);
        chk("flags_cnt", retired_cnt, 13);

        // stall holds everything
        stall = 1; branch = 1; imm9 = 9'h004; set_z = 1; alu_result = 16'h0005;
        repeat (3) begin
            step();
            chk("stall_pc", pc, 16'h0006);
            chk("stall_cnt", retired_cnt, 13);
            chk("stall_z", flag_z, 1);
        end
        stall = 0; step(); branch = 0; set_z = 0;
        chk("unstall_pc", pc, 16'h0010);
        chk("unstall_z", flag_z, 0);
        chk("unstall_cnt", retired_cnt, 14);

        // halt
        br_reg = 1; rs_data = 16'h0020; step(); br_reg = 0;
        pc_write = 0; step();
        chk("hlt_halted", halted, 1);
        chk("hlt_pc", pc, 16'h0020);
        chk("hlt_cnt", retired_cnt, 16);
        pc_write = 1; br_reg = 1; rs_data = 16'h0040; set_n = 1; alu_result = 16'h0000;
        repeat (2) step();
        chk("hlt_hold_pc", pc, 16'h0020);
        chk("hlt_hold_cnt", retired_cnt, 16);
        chk("hlt_hold_n", flag_n, 1);
        chk("hlt_hold_halt", halted, 1);
        #3;
        rst_n = 0;
        #1;
        chk("async_pc", pc, 0);
        chk("async_halted", halted, 0);
        chk("async_cnt", retired_cnt, 0);
        @(negedge clk);
        rst_n = 1;
        idle_inputs();
        #1;

        // counter saturation
        repeat (35) step();
        chk("sat_cnt", retired_cnt, 31);
        chk("sat_pc", pc, 16'h0046);
        chk("sat_halted", halted, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
